// File: rtl/td4_datapath.sv
// td4_datapath: register/ALU stage of the TD4 CPU.
// Holds registers A, B, OUT, PC and the carry flag C. A source mux selects A, B,
// IN or zero. Its output is added to the instruction immediate. The sum loads
// whichever registers the active-low ld vector selects. PC loads the sum, or
// increments when ld[3] is high.
// Optional build macro: TD4_STEP_EN adds a single-step button input 'step'.
// When it is defined, state updates only on a synchronized rising edge of step.
// PC_WIDTH must lie between 2 and WIDTH inclusive.
module td4_datapath #(
  parameter int WIDTH    = 4,
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef TD4_STEP_EN
  input  logic                step,
`endif
  input  logic [1:0]          sel,
  input  logic [3:0]          ld,
  input  logic [WIDTH-1:0]    im,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    a,
  output logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    out_port,
  output logic [PC_WIDTH-1:0] pc,
  output logic                c
);

  localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]    ZERO_W  = {WIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0] ZERO_PC = {PC_WIDTH{1'b0}};

  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                c_q, c_d;

  logic [WIDTH-1:0]    src_s;
  logic [WIDTH:0]      add_s;
  logic [WIDTH-1:0]    sum_s;
  logic                co_s;
  logic                en_s;

`ifdef TD4_STEP_EN
  // The step button is asynchronous. Two flops resynchronize it, and a third
  // flop remembers the previous synchronized level for edge detection.
  logic [1:0] step_sync_q;
  logic       step_prev_q;

  // Synchronize the step button and keep its previous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync_q <= 2'b00;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[0], step};
      step_prev_q <= step_sync_q[1];
    end
  end

  assign en_s = step_sync_q[1] & ~step_prev_q;
`else
  assign en_s = 1'b1;
`endif

  // Source mux. Every code other than 00/01/10, including unknowns, selects zero.
  always_comb begin
    src_s = ZERO_W;
    case (sel)
      2'b00:   src_s = a_q;
      2'b01:   src_s = b_q;
      2'b10:   src_s = in_port;
      default: src_s = ZERO_W;
    endcase
  end

  // Adder with no carry-in. The extra top bit is the carry-out.
  always_comb begin
    add_s = {1'b0, src_s} + {1'b0, im};
    sum_s = add_s[WIDTH-1:0];
    co_s  = add_s[WIDTH];
  end

  // Next state. Only an explicit 0 on a load bit loads. Several low bits all
  // load the same sum. C takes the carry on every enabled edge.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    if (en_s) begin
      if (ld[0] == 1'b0) a_d = sum_s;
      else               a_d = a_q;
      if (ld[1] == 1'b0) b_d = sum_s;
      else               b_d = b_q;
      if (ld[2] == 1'b0) out_d = sum_s;
      else               out_d = out_q;
      if (ld[3] == 1'b0) pc_d = sum_s[PC_WIDTH-1:0];
      else               pc_d = pc_q + PC_ONE;
      c_d = co_s;
    end else begin
      a_d   = a_q;
      b_d   = b_q;
      out_d = out_q;
      pc_d  = pc_q;
      c_d   = c_q;
    end
  end

  // Architectural state registers. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= ZERO_W;
      b_q   <= ZERO_W;
      out_q <= ZERO_W;
      pc_q  <= ZERO_PC;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign out_port = out_q;
  assign pc       = pc_q;
  assign c        = c_q;

endmodule

// File: tb/tb_td4_datapath.sv
// tb_td4_datapath: directed-vector bench for td4_datapath with hand-computed expectations.
// Build with TD4_STEP_EN defined to exercise the single-step variant.
module tb_td4_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sel = 2'b11;
  logic [3:0] ld  = 4'b1111;
  logic [3:0] im  = 4'h0;
  logic [3:0] in_port = 4'h0;
  logic [3:0] a, b, out_port, pc;
  logic       c;
`ifdef TD4_STEP_EN
  logic       step = 1'b0;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  td4_datapath #(.WIDTH(4), .PC_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef TD4_STEP_EN
    .step     (step),
`endif
    .sel      (sel),
    .ld       (ld),
    .im       (im),
    .in_port  (in_port),
    .a        (a),
    .b        (b),
    .out_port (out_port),
    .pc       (pc),
    .c        (c)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Apply one instruction and return 1 time unit after the edge that executes it.
  task automatic run(input logic [1:0] s, input logic [3:0] l, input logic [3:0] i);
    sel = s;
    ld  = l;
    im  = i;
`ifdef TD4_STEP_EN
    step = 1'b1;
    repeat (4) @(posedge clk);
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) run(2'b11, 4'b1111, 4'h0);
  endtask

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_a", a, 4'h0);
    check("rst_b", b, 4'h0);
    check("rst_out", out_port, 4'h0);
    check("rst_pc", pc, 4'h0);
    check("rst_c", {3'b000, c}, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // MOV A,5 then ADD A,B. The second add overflows: 5+B = 0x10.
    run(2'b11, 4'b1110, 4'h5);
    check("mov_a", a, 4'h5);
    check("mov_c", {3'b000, c}, 4'h0);
    check("mov_pc", pc, 4'h1);
    run(2'b00, 4'b1110, 4'hB);
    check("add_a", a, 4'h0);
    check("add_c", {3'b000, c}, 4'h1);
    check("add_pc", pc, 4'h2);

    // IN B, then OUT B.
    in_port = 4'h9;
    run(2'b10, 4'b1101, 4'h0);
    check("in_b", b, 4'h9);
    check("in_c", {3'b000, c}, 4'h0);
    check("in_a", a, 4'h0);
    check("in_pc", pc, 4'h3);
    run(2'b01, 4'b1011, 4'h0);
    check("out_port", out_port, 4'h9);
    check("out_a", a, 4'h0);
    check("out_pc", pc, 4'h4);

    // Jump from pc=7 to 3, then wrap PC around F -> 0.
    nops(3);
    check("pc_7", pc, 4'h7);
    run(2'b11, 4'b0111, 4'h3);
    check("jmp_pc", pc, 4'h3);
    check("jmp_c", {3'b000, c}, 4'h0);
    nops(11);
    check("pc_e", pc, 4'hE);
    nops(1);
    check("pc_f", pc, 4'hF);
    nops(1);
    check("pc_wrap", pc, 4'h0);
    nops(14);
    check("pc_e2", pc, 4'hE);

    // A=F then A+1 overflows to 0 with C=1. A NOP afterwards clears C.
    run(2'b11, 4'b1110, 4'hF);
    check("a_f", a, 4'hF);
    run(2'b00, 4'b1110, 4'h1);
    check("ovf_a", a, 4'h0);
    check("ovf_c", {3'b000, c}, 4'h1);
    check("ovf_pc", pc, 4'h0);
    nops(1);
    check("nop_c", {3'b000, c}, 4'h0);
    check("nop_pc", pc, 4'h1);

    // Multiple load bits low: A, B and OUT all take the same sum.
    run(2'b11, 4'b1000, 4'h6);
    check("multi_a", a, 4'h6);
    check("multi_b", b, 4'h6);
    check("multi_out", out_port, 4'h6);
    check("multi_pc", pc, 4'h2);

    // Jump with a carry: 6 + C = 0x12. PC becomes 2 and C is set.
    run(2'b00, 4'b0111, 4'hC);
    check("jc_pc", pc, 4'h2);
    check("jc_c", {3'b000, c}, 4'h1);
    check("jc_a", a, 4'h6);

    // Load A from A uses the pre-edge value: 6+3.
    run(2'b00, 4'b1110, 4'h3);
    check("aa_a", a, 4'h9);
    check("aa_pc", pc, 4'h3);

    // Unknown select with a NOP: every possible source is zero here, so C stays 0.
    in_port = 4'h0;
    run(2'b11, 4'b1000, 4'h0);
    run(2'bxx, 4'b1111, 4'h7);
    check("x_a", a, 4'h0);
    check("x_b", b, 4'h0);
    check("x_out", out_port, 4'h0);
    check("x_c", {3'b000, c}, 4'h0);
    check("x_pc", pc, 4'h5);

    // Reset in the middle of a run clears everything at once.
    run(2'b11, 4'b1000, 4'h5);
    run(2'b00, 4'b1110, 4'hF);
    check("pre_rst_a", a, 4'h4);
    check("pre_rst_c", {3'b000, c}, 4'h1);
    check("pre_rst_pc", pc, 4'h7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_a", a, 4'h0);
    check("mid_rst_b", b, 4'h0);
    check("mid_rst_out", out_port, 4'h0);
    check("mid_rst_pc", pc, 4'h0);
    check("mid_rst_c", {3'b000, c}, 4'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rel_pc", pc, 4'h0);
    nops(1);
    check("rel_pc1", pc, 4'h1);
    nops(1);
    check("rel_pc2", pc, 4'h2);
    nops(1);
    check("rel_pc3", pc, 4'h3);

`ifdef TD4_STEP_EN
    // With step held low the state stays frozen.
    sel = 2'b11; ld = 4'b1111; im = 4'h0;
    repeat (10) @(posedge clk);
    #1;
    check("frozen_pc", pc, 4'h3);
    // One press held for 10 clocks produces exactly one update.
    step = 1'b1;
    repeat (10) @(posedge clk);
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("step_once_pc", pc, 4'h4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
